keccak_padder: RTL and testbench
================================

Name: keccak_padder

Overview:
- Upstream stage of the rate-block serializer in the Keccak datapath.
- Collects a byte-aligned message arriving as DATA_SIZE-bit words and assembles it into RATE-bit rate blocks.
- Applies Keccak pad10*1 padding with a fixed domain-separation byte.
- Presents each completed block with a valid/ready handshake, in the same MSB-first layout the serializer shifts out (first word in block bits RATE-1 down to RATE-DATA_SIZE).

Parameters:
- DATA_SIZE, 64, input word width in bits. Must be a multiple of 8 and must divide RATE.
- RATE, 1344, block width in bits (SHAKE128 rate).
- DOMAIN, 8'h1F, domain-separation/first-pad byte (8'h06 for SHA3).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_data, input, DATA_SIZE, message word; byte 0 is in_data[DATA_SIZE-1 -: 8].
- in_valid, input, 1, in_data/in_last/in_bytes are valid.
- in_last, input, 1, this word is the final word of the message.
- in_bytes, input, $clog2(DATA_SIZE/8)+1, number of valid leading bytes in the last word (0..DATA_SIZE/8). Ignored unless in_last=1.
- in_ready, output, 1, block accepts a word this cycle.
- block_out, output, RATE, assembled padded block.
- block_valid, output, 1, block_out is complete and stable.
- block_last, output, 1, block_out is the final block of the message.
- block_ready, input, 1, consumer takes the block this cycle.

Behaviour:
- Derived constants:
  - BPW = DATA_SIZE/8
  - WORDS = RATE/DATA_SIZE (21 at defaults)
  - Internal word_cnt, 0..WORDS-1.
- Word placement: word k of a block is written to block bits RATE-1-k*DATA_SIZE downward. Message byte j of a block sits at bits RATE-1-8j downward.
- States: FILL, HOLD.
- Reset (rst=1 at a clock edge):
  - state=FILL, word_cnt=0, pending_extra=0.
  - block_out=0, block_valid=0, block_last=0; in_ready=1 after reset.
  - Reset mid-message discards all partial data.
- in_ready = (state==FILL), combinational. block_valid = (state==HOLD), registered.
- FILL, word accepted (in_valid & in_ready):
  - Non-last word: store the word.
    - If word_cnt==WORDS-1: go to HOLD with block_last=0 and word_cnt=0.
    - Otherwise: word_cnt++.
  - Last word, in_bytes<BPW:
    - Bytes at and beyond in_bytes are forced to 0.
    - Byte in_bytes of this word is set to DOMAIN.
    - All later words are 0.
    - Block byte RATE/8-1 (bits 7:0) is ORed with 8'h80.
    - Go to HOLD with block_last=1.
  - Last word, in_bytes==BPW and word_cnt<WORDS-1: DOMAIN goes to byte 0 of word word_cnt+1, plus the same 0x80 OR. Go to HOLD with block_last=1.
  - Last word, in_bytes==BPW and word_cnt==WORDS-1 (exact block boundary): go to HOLD with block_last=0 and set pending_extra=1.
- Domain and final byte coincide (last message byte is RATE/8-2): the final byte is DOMAIN|8'h80 (8'h9F at defaults).
- Latency: block_valid rises the cycle after the completing word is accepted.
- HOLD:
  - block_out stays stable and in_valid is ignored until block_ready=1.
  - On a cycle with block_ready=1:
    - If pending_extra: load the extra block (top byte DOMAIN, bits 7:0 = 8'h80, all else 0), set block_last=1, clear pending_extra, stay in HOLD.
    - Otherwise: block_out cleared to 0, block_valid=0, block_last=0, state returns to FILL. in_ready=1 the next cycle; no bubble beyond that.
- in_valid with in_ready=0 is not consumed; the upstream holds its data.
- Message continuity: the next message starts at word 0 of a fresh, zeroed block.

Optional Feature:
- Macro PADDER_LEN_CNT_EN.
- When defined:
  - Adds output port msg_len [31:0], the count of message bytes accepted for the current message.
  - Each accepted non-last word adds BPW. The last word adds in_bytes.
  - msg_len is cleared to 0 on the first accepted word of a new message, before that word's contribution is added.
  - Reset value is 0. msg_len wraps modulo 2^32.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan (defaults):
- Empty message: one beat with in_last=1, in_bytes=0 -> block_out[1343:1336]=8'h1F, block_out[7:0]=8'h80, all other bits 0, block_last=1, block_valid high 1 cycle after the beat.
- 3-byte message: in_data=64'hAABBCC11_22334455, in_last=1, in_bytes=3 -> block_out[1343:1320]=24'hAABBCC, [1319:1312]=8'h1F, [1311:8]=0, [7:0]=8'h80.
- 167-byte message: 20 full words, then a last word with in_bytes=7 -> single block, block_out[7:0]=8'h9F, block_last=1.
- 168-byte message: 21 full words, the last with in_bytes=8 -> block 1 holds the data with block_last=0. After block_ready, block 2 has [1343:1336]=8'h1F, [7:0]=8'h80, block_last=1. Then FILL.
- Backpressure: block_ready=0 for 10 cycles in HOLD while in_valid=1 -> in_ready=0 throughout, block_out unchanged, no words consumed. Release -> FILL the next cycle.
- Reset mid-fill: rst after 5 accepted words -> block_valid=0 and in_ready=1 next cycle. A following 1-byte message 8'h5A yields [1343:1336]=8'h5A, [1335:1328]=8'h1F, [7:0]=8'h80. With PADDER_LEN_CNT_EN defined, msg_len=1.

Source files
------------

// File: rtl/keccak_padder.sv
// Packs byte-aligned message words into RATE-bit blocks with Keccak pad10*1 and DOMAIN byte.
// Optional byte counter output msg_len enabled by defining PADDER_LEN_CNT_EN.
module keccak_padder #(
    parameter int         DATA_SIZE = 64,
    parameter int         RATE      = 1344,
    parameter logic [7:0] DOMAIN    = 8'h1F
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_SIZE-1:0]           in_data,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic [$clog2(DATA_SIZE/8):0]   in_bytes,
    output logic                           in_ready,
    output logic [RATE-1:0]                block_out,
    output logic                           block_valid,
    output logic                           block_last,
    input  logic                           block_ready
`ifdef PADDER_LEN_CNT_EN
    ,
    output logic [31:0]                    msg_len
`endif
);
    localparam int BPW   = DATA_SIZE / 8;
    localparam int WORDS = RATE / DATA_SIZE;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BW    = $clog2(BPW) + 1;
    localparam logic [CW-1:0] LAST_W = CW'(WORDS - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 last_q, last_d;
    logic [RATE-1:0]      block_q, block_d;
    logic [DATA_SIZE-1:0] word_m;
    logic                 full_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            block_q <= block_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        last_d    = last_q;
        block_d   = block_q;
        full_last = in_last && (in_bytes >= BW'(BPW));
        // Last word: zero trailing bytes and drop DOMAIN right after the message
        word_m    = in_data;
        for (int b = 0; b < BPW; b++) begin
            if (in_last && (BW'(b) >= in_bytes))
                word_m[DATA_SIZE-1-8*b -: 8] = (BW'(b) == in_bytes) ? DOMAIN : 8'h00;
        end

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (cnt_q == CW'(k))
                            block_d[RATE-1-k*DATA_SIZE -: DATA_SIZE] = word_m;
                    end
                    for (int k = 0; k < WORDS - 1; k++) begin
                        if (full_last && (cnt_q == CW'(k)))
                            block_d[RATE-1-(k+1)*DATA_SIZE -: 8] = DOMAIN;
                    end
                    if (in_last && !(full_last && (cnt_q == LAST_W))) begin
                        block_d[7:0] = block_d[7:0] | 8'h80;
                        last_d       = 1'b1;
                        state_d      = HOLD;
                        cnt_d        = '0;
                    end else if (in_last) begin
                        // Message ends exactly on a block boundary: padding needs its own block
                        last_d  = 1'b0;
                        pend_d  = 1'b1;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_W) begin
                        last_d  = 1'b0;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (block_ready) begin
                    block_d = '0;
                    if (pend_q) begin
                        block_d[RATE-1 -: 8] = DOMAIN;
                        block_d[7:0]         = block_d[7:0] | 8'h80;
                        last_d               = 1'b1;
                        pend_d               = 1'b0;
                    end else begin
                        last_d  = 1'b0;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

`ifdef PADDER_LEN_CNT_EN
    logic [31:0] len_q, len_d;
    logic        start_q, start_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            start_q <= 1'b1;
        end else begin
            len_q   <= len_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        len_d   = len_q;
        start_d = start_q;
        if (in_valid && (state_q == FILL)) begin
            len_d   = (start_q ? 32'd0 : len_q) + (in_last ? 32'(in_bytes) : 32'(BPW));
            start_d = in_last;
        end
    end

    assign msg_len = len_q;
`endif

    assign in_ready    = (state_q == FILL);
    assign block_out   = block_q;
    assign block_valid = (state_q == HOLD);
    assign block_last  = last_q;
endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder: a byte-level pad10*1 model fills a scoreboard of expected blocks.
module tb_keccak_padder;
    localparam int         DS   = 64;
    localparam int         RATE = 1344;
    localparam int         RB   = RATE / 8;
    localparam logic [7:0] DOM  = 8'h1F;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [RATE-1:0] blk;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DS-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [3:0]      in_bytes = '0;
    logic            in_ready;
    logic [RATE-1:0] block_out;
    logic            block_valid;
    logic            block_last;
    logic            block_ready = 1'b1;
`ifdef PADDER_LEN_CNT_EN
    logic [31:0]     msg_len;
`endif

    exp_t sb[$];
    exp_t mon_e;
    bq_t  m;
    int   checks = 0;
    int   failures = 0;

    keccak_padder dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .in_bytes(in_bytes),
        .in_ready(in_ready),
        .block_out(block_out),
        .block_valid(block_valid),
        .block_last(block_last),
        .block_ready(block_ready)
`ifdef PADDER_LEN_CNT_EN
        ,
        .msg_len(msg_len)
`endif
    );

    always #5 clk = ~clk;

    task automatic report_diff(input string tag, input logic [RATE-1:0] got, input logic [RATE-1:0] exp);
        int idx;
        idx = -1;
        for (int j = RB - 1; j >= 0; j--)
            if (got[RATE-1-8*j -: 8] !== exp[RATE-1-8*j -: 8]) idx = j;
        if (idx >= 0)
            $error("FAIL %s byte=%0d got=%h exp=%h", tag, idx, got[RATE-1-8*idx -: 8], exp[RATE-1-8*idx -: 8]);
        else
            $error("FAIL %s got/exp differ in X/Z bits", tag);
    endtask

    // Scoreboard sink: each accepted block is compared with the oldest expected one
    always @(negedge clk) begin
        if (!rst && block_valid === 1'b1 && block_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_block got=1 exp=0");
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                checks++;
                assert (block_out === mon_e.blk) else begin
                    failures++;
                    report_diff("block_out", block_out, mon_e.blk);
                end
                checks++;
                assert (block_last === mon_e.last) else begin
                    failures++;
                    $error("FAIL block_last got=%b exp=%b", block_last, mon_e.last);
                end
            end
        end
    end

    task automatic push_exp(input bq_t msg);
        int   n, tot;
        bq_t  pad;
        exp_t e;
        n   = msg.size();
        tot = (n / RB + 1) * RB;
        pad = msg;
        pad.push_back(DOM);
        while (pad.size() < tot) pad.push_back(8'h00);
        pad[tot-1] = pad[tot-1] | 8'h80;
        for (int b = 0; b < tot / RB; b++) begin
            e.blk = '0;
            for (int j = 0; j < RB; j++) e.blk[RATE-1-8*j -: 8] = pad[b*RB+j];
            e.last = (b == tot / RB - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_word(input logic [DS-1:0] d, input logic l, input logic [3:0] nb);
        int w;
        in_data  = d;
        in_last  = l;
        in_bytes = nb;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            failures++;
            $error("FAIL accept_timeout got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg);
        int            n, nw, nb;
        logic [DS-1:0] d;
        n  = msg.size();
        nw = (n == 0) ? 1 : (n + 7) / 8;
        push_exp(msg);
        for (int w = 0; w < nw; w++) begin
            d  = {$urandom, $urandom};
            nb = (w == nw - 1) ? n - 8 * (nw - 1) : 8;
            for (int j = 0; j < 8; j++)
                if (w * 8 + j < n) d[DS-1-8*j -: 8] = msg[w*8+j];
            send_word(d, (w == nw - 1), 4'(nb));
        end
        @(negedge clk);
        checks++;
        assert (block_valid === 1'b1) else begin
            failures++;
            $error("FAIL latency_valid got=%b exp=1", block_valid);
        end
`ifdef PADDER_LEN_CNT_EN
        checks++;
        assert (msg_len === 32'(n)) else begin
            failures++;
            $error("FAIL msg_len got=%0d exp=%0d", msg_len, n);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drain_timeout got=%0d exp=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_msg(input int n);
        m = {};
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (block_out === '0) else begin failures++; $error("FAIL rst_block_out got=%h exp=0", block_out[63:0]); end
        checks++;
        assert (block_valid === 1'b0) else begin failures++; $error("FAIL rst_valid got=%b exp=0", block_valid); end
        checks++;
        assert (block_last === 1'b0) else begin failures++; $error("FAIL rst_last got=%b exp=0", block_last); end
        checks++;
        assert (in_ready === 1'b1) else begin failures++; $error("FAIL rst_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;

        // Empty, short, padding-coincident, exact-boundary and multi-block messages
        m = {};
        send_msg(m);
        m = {};
        m.push_back(8'hAA); m.push_back(8'hBB); m.push_back(8'hCC);
        send_msg(m);
        rand_msg(167); send_msg(m);
        rand_msg(168); send_msg(m);
        drain();
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b1) else begin failures++; $error("FAIL fill_after_extra got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
        rand_msg(200); send_msg(m);
        rand_msg(11);  send_msg(m);
        drain();

        // Backpressure: block held while upstream keeps offering a word
        block_ready = 1'b0;
        m = {};
        m.push_back(8'h01); m.push_back(8'h02); m.push_back(8'h03);
        send_msg(m);
        in_data  = {$urandom, $urandom};
        in_last  = 1'b1;
        in_bytes = 4'd2;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            assert (in_ready === 1'b0) else begin failures++; $error("FAIL hold_in_ready got=%b exp=0", in_ready); end
            checks++;
            assert (block_out === sb[0].blk) else begin failures++; report_diff("hold_block_out", block_out, sb[0].blk); end
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b1) else begin failures++; $error("FAIL release_in_ready got=%b exp=1", in_ready); end
        checks++;
        assert (block_valid === 1'b0) else begin failures++; $error("FAIL release_valid got=%b exp=0", block_valid); end
        @(posedge clk);
        #1;

        // Reset in the middle of a message discards the partial block
        for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b0, 4'd8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (block_valid === 1'b0) else begin failures++; $error("FAIL midrst_valid got=%b exp=0", block_valid); end
        checks++;
        assert (in_ready === 1'b1) else begin failures++; $error("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
        m = {};
        m.push_back(8'h5A);
        send_msg(m);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
